// File: rtl/serial_load_ctrl.sv
// Parallel-to-serial load controller: shifts a captured word out MSB first with a strobe every DIV cycles.
// Optional macro SER_PARITY_EN appends an even-parity bit after the data bits.
module serial_load_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] data_in,
   output logic             dI,
   output logic             dS,
   output logic             busy,
   output logic             done
);

`ifdef SER_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int BCW = $clog2(WIDTH + 2);
   localparam int DCW = $clog2(DIV) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [NBITS-1:0] shadow_r;
   logic [NBITS-1:0] load_word_s;
   logic [BCW-1:0]   bitcnt_r;
   logic [DCW-1:0]   divcnt_r;
   logic             div_wrap_s;

`ifdef SER_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] word);
      return ^word;
   endfunction

   assign load_word_s = {data_in, even_parity(data_in)};
`else
   assign load_word_s = data_in;
`endif

   assign div_wrap_s = (divcnt_r == DCW'(DIV - 1));

   // State register
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; abort outranks the final-bit transition
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = SHIFT;
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_next_s = IDLE;
            end else if (div_wrap_s && (bitcnt_r == BCW'(1))) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Output decode from state and counters
   always_comb begin
      dS   = 1'b0;
      dI   = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state_r)
         SHIFT: begin
            busy = 1'b1;
            dS   = div_wrap_s;
            dI   = shadow_r[NBITS-1];
         end
         DONE:    done = 1'b1;
         default: done = 1'b0;
      endcase
   end

   // Shadow word and bit/divider counters
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         shadow_r <= {NBITS{1'b0}};
         bitcnt_r <= {BCW{1'b0}};
         divcnt_r <= {DCW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  shadow_r <= load_word_s;
                  bitcnt_r <= BCW'(NBITS);
                  divcnt_r <= {DCW{1'b0}};
               end
            end
            SHIFT: begin
               if (div_wrap_s) begin
                  divcnt_r <= {DCW{1'b0}};
                  shadow_r <= {shadow_r[NBITS-2:0], 1'b0};
                  bitcnt_r <= bitcnt_r - BCW'(1);
               end else begin
                  divcnt_r <= divcnt_r + DCW'(1);
               end
            end
            default: begin
               divcnt_r <= divcnt_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Directed self-checking bench for serial_load_ctrl (default build and SER_PARITY_EN build).
module tb_serial_load_ctrl;

`ifdef SER_PARITY_EN
   localparam int NB  = 9;
   localparam int NB4 = 5;
`else
   localparam int NB  = 8;
   localparam int NB4 = 4;
`endif

   logic       clock = 1'b0;
   logic       clear = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       dI, dS, busy, done;

   logic       start4 = 1'b0;
   logic       abort4 = 1'b0;
   logic [3:0] data4 = 4'h0;
   logic       dI4, dS4, busy4, done4;

   int checks = 0;
   int errors = 0;

   serial_load_ctrl #(.WIDTH(8), .DIV(4)) u_dut (
      .clock(clock), .clear(clear), .start(start), .abort(abort),
      .data_in(data_in), .dI(dI), .dS(dS), .busy(busy), .done(done)
   );

   serial_load_ctrl #(.WIDTH(4), .DIV(1)) u_dut4 (
      .clock(clock), .clear(clear), .start(start4), .abort(abort4),
      .data_in(data4), .dI(dI4), .dS(dS4), .busy(busy4), .done(done4)
   );

   always #5 clock = ~clock;

   // Expected serial bit k of a frame: data MSB first, then even parity when enabled
   function automatic logic frame_bit(input logic [7:0] w, input int k);
      if (k < 8) return w[7-k];
      return ^w;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      start = 1'b0; abort = 1'b0; start4 = 1'b0;
      #2 clear = 1'b0;
      step();
      #2 clear = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #2;
      checks += 2;
      if ({dI, dS, busy, done} !== 4'b0000) begin
         errors++; $display("FAIL reset_outputs: got %b expected 0000", {dI, dS, busy, done});
      end
      if ({dI4, dS4, busy4, done4} !== 4'b0000) begin
         errors++; $display("FAIL reset_outputs4: got %b expected 0000", {dI4, dS4, busy4, done4});
      end
   endtask

   // One frame with a start pulse at edge 0, checked cycle by cycle
   task automatic test_basic_frame();
      logic [7:0] w;
      logic e_ds, e_busy, e_done;
      do_reset();
      w = 8'hA5; data_in = w; start = 1'b1;
      step();
      start = 1'b0; data_in = 8'h00;
      for (int c = 1; c <= 4*NB + 3; c++) begin
         e_ds   = (c % 4 == 0) && (c <= 4*NB);
         e_busy = (c <= 4*NB);
         e_done = (c == 4*NB + 1);
         checks += 3;
         if (dS !== e_ds) begin errors++; $display("FAIL basic_ds cycle %0d: got %b expected %b", c, dS, e_ds); end
         if (busy !== e_busy) begin errors++; $display("FAIL basic_busy cycle %0d: got %b expected %b", c, busy, e_busy); end
         if (done !== e_done) begin errors++; $display("FAIL basic_done cycle %0d: got %b expected %b", c, done, e_done); end
         if (e_ds) begin
            checks++;
            if (dI !== frame_bit(w, c/4 - 1)) begin
               errors++; $display("FAIL basic_di cycle %0d: got %b expected %b", c, dI, frame_bit(w, c/4 - 1));
            end
         end else if (!e_busy) begin
            checks++;
            if (dI !== 1'b0) begin errors++; $display("FAIL basic_di_idle cycle %0d: got %b expected 0", c, dI); end
         end
         step();
      end
   endtask

   // Start held high: frames repeat with one IDLE cycle in between
   task automatic test_back_to_back();
      localparam int P = 4*NB + 2;
      logic [7:0] w;
      int lc;
      logic e_ds, e_busy, e_done;
      do_reset();
      w = 8'h3C; data_in = w; start = 1'b1;
      step();
      for (int c = 1; c <= 2*P; c++) begin
         lc = (c - 1) % P + 1;
         e_ds   = (lc % 4 == 0) && (lc <= 4*NB);
         e_busy = (lc <= 4*NB);
         e_done = (lc == 4*NB + 1);
         checks += 3;
         if (dS !== e_ds) begin errors++; $display("FAIL b2b_ds cycle %0d: got %b expected %b", c, dS, e_ds); end
         if (busy !== e_busy) begin errors++; $display("FAIL b2b_busy cycle %0d: got %b expected %b", c, busy, e_busy); end
         if (done !== e_done) begin errors++; $display("FAIL b2b_done cycle %0d: got %b expected %b", c, done, e_done); end
         if (e_ds) begin
            checks++;
            if (dI !== frame_bit(w, lc/4 - 1)) begin
               errors++; $display("FAIL b2b_di cycle %0d: got %b expected %b", c, dI, frame_bit(w, lc/4 - 1));
            end
         end
         step();
      end
      start = 1'b0;
   endtask

   // Abort in cycle 14, then abort on the final-bit cycle
   task automatic test_abort();
      int strobes;
      int done_seen;
      do_reset();
      data_in = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      strobes = 0; done_seen = 0;
      for (int c = 1; c <= 14; c++) begin
         if (dS === 1'b1) strobes++;
         if (c == 14) abort = 1'b1;
         step();
      end
      abort = 1'b0;
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy cycle 15: got %b expected 0", busy); end
      if (dS !== 1'b0) begin errors++; $display("FAIL abort_ds cycle 15: got %b expected 0", dS); end
      if (strobes != 3) begin errors++; $display("FAIL abort_strobes: got %0d expected 3", strobes); end
      for (int c = 15; c <= 40; c++) begin
         if (done === 1'b1) done_seen++;
         step();
      end
      checks++;
      if (done_seen != 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_seen); end

      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 4*NB; c++) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks += 2;
      if (done !== 1'b0) begin errors++; $display("FAIL abort_last_done: got %b expected 0", done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_last_busy: got %b expected 0", busy); end
   endtask

   // Asynchronous clear in cycle 20 (a strobe cycle), then a fresh frame right after release
   task automatic test_reset_mid_frame();
      logic [7:0] w;
      int strobes;
      int done_cycle;
      do_reset();
      data_in = 8'hFF; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 20; c++) step();
      checks++;
      if ({busy, dS, dI} !== 3'b111) begin errors++; $display("FAIL rst_pre cycle 20: got %b expected 111", {busy, dS, dI}); end
      #2 clear = 1'b0;
      #1;
      checks += 2;
      if ({busy, dS, dI} !== 3'b000) begin errors++; $display("FAIL rst_async: got %b expected 000", {busy, dS, dI}); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
      step();
      #2 clear = 1'b1;
      w = 8'h5A; data_in = w; start = 1'b1;
      step();
      start = 1'b0;
      strobes = 0; done_cycle = 0;
      for (int c = 1; c <= 4*NB + 4; c++) begin
         if (dS === 1'b1) begin
            checks++;
            if (dI !== frame_bit(w, strobes)) begin
               errors++; $display("FAIL rst_frame_di bit %0d: got %b expected %b", strobes, dI, frame_bit(w, strobes));
            end
            strobes++;
         end
         if (done === 1'b1 && done_cycle == 0) done_cycle = c;
         step();
      end
      checks += 2;
      if (strobes != NB) begin errors++; $display("FAIL rst_frame_strobes: got %0d expected %0d", strobes, NB); end
      if (done_cycle != 4*NB + 1) begin errors++; $display("FAIL rst_frame_done: got cycle %0d expected %0d", done_cycle, 4*NB + 1); end
   endtask

   // DIV=1, WIDTH=4 instance with 4'b1001
   task automatic test_div1();
      logic [4:0] exp_bits;
      logic e_ds, e_done;
      exp_bits = 5'b10010;
      do_reset();
      data4 = 4'b1001; start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int c = 1; c <= NB4 + 2; c++) begin
         e_ds   = (c <= NB4);
         e_done = (c == NB4 + 1);
         checks += 3;
         if (dS4 !== e_ds) begin errors++; $display("FAIL div1_ds cycle %0d: got %b expected %b", c, dS4, e_ds); end
         if (busy4 !== e_ds) begin errors++; $display("FAIL div1_busy cycle %0d: got %b expected %b", c, busy4, e_ds); end
         if (done4 !== e_done) begin errors++; $display("FAIL div1_done cycle %0d: got %b expected %b", c, done4, e_done); end
         if (e_ds) begin
            checks++;
            if (dI4 !== exp_bits[5-c]) begin
               errors++; $display("FAIL div1_di cycle %0d: got %b expected %b", c, dI4, exp_bits[5-c]);
            end
         end
         step();
      end
   endtask

`ifdef SER_PARITY_EN
   // Parity build: 8'h07 gives nine strobes, ninth bit 1, done in cycle 37
   task automatic test_parity();
      int strobes;
      int done_cycle;
      logic ninth;
      do_reset();
      data_in = 8'h07; start = 1'b1;
      step();
      start = 1'b0;
      strobes = 0; done_cycle = 0; ninth = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (dS === 1'b1) begin
            strobes++;
            if (strobes == 9) ninth = dI;
         end
         if (done === 1'b1 && done_cycle == 0) done_cycle = c;
         step();
      end
      checks += 3;
      if (strobes != 9) begin errors++; $display("FAIL parity_strobes: got %0d expected 9", strobes); end
      if (ninth !== 1'b1) begin errors++; $display("FAIL parity_bit: got %b expected 1", ninth); end
      if (done_cycle != 37) begin errors++; $display("FAIL parity_done: got cycle %0d expected 37", done_cycle); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_frame();
      test_back_to_back();
      test_abort();
      test_reset_mid_frame();
      test_div1();
`ifdef SER_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_load_ctrl.md
SERIAL_LOAD_CTRL -- requirements
Module: serial_load_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of data bits per frame (minimum 2).
REQ-002 SHALL have parameter DIV, default 4, the clock cycles per serial bit (minimum 1).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a frame in progress.
REQ-007 SHALL have port data_in  input  WIDTH  parallel word, captured on an accepted start.
REQ-008 SHALL have port dI  output  1  serial data bit to the shift-register datapath, MSB first.
REQ-009 SHALL have port dS  output  1  one-cycle shift strobe; the datapath samples dI when dS=1.
REQ-010 SHALL have port busy  output  1  high while in state SHIFT.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final bit of a frame.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL leave IDLE only when start=1 at a rising edge.
REQ-014 SHALL, on that edge, load data_in into a shadow register, set bitcnt=WIDTH and divcnt=0, and enter SHIFT.
REQ-015 SHALL, in SHIFT, increment divcnt each cycle, wrapping from DIV-1 to 0.
REQ-016 SHALL drive dS=1 combinationally in exactly those SHIFT cycles with divcnt==DIV-1; dS=1 on every SHIFT cycle when DIV=1.
REQ-017 SHALL drive dI from the shadow MSB, stable in every cycle where dS=1; dI=0 outside SHIFT.
REQ-018 SHALL, on each edge where dS=1, shift the shadow register left by one and decrement bitcnt.
REQ-019 SHALL enter DONE on the edge where dS=1 and bitcnt==1.
REQ-020 SHALL stay in DONE for exactly one cycle with done=1, then return to IDLE.
REQ-021 SHALL produce, for a start accepted at edge 0, a first dS in cycle DIV, the last dS in cycle WIDTH*DIV, and done in cycle WIDTH*DIV+1 (defaults: 4, 32, 33).
REQ-022 SHALL ignore start in SHIFT and DONE, with no queuing.
REQ-023 SHALL, when abort=1 in SHIFT, return to IDLE on the next edge with no done pulse and no dS in the following cycle; abort has priority over the final-bit transition.
REQ-024 SHALL ignore abort in IDLE and DONE.
REQ-025 SHALL use a bitcnt width of clog2(WIDTH+2) and a divcnt width of clog2(DIV)+1, with no overflow at any parameter value.

Reset
REQ-026 SHALL, while clear=0 (independent of clock), force state=IDLE, shadow=0, bitcnt=0 and divcnt=0, which gives dI=0, dS=0, busy=0 and done=0.
REQ-027 SHALL, on reset asserted mid-frame, drop busy and dS immediately and produce no done pulse.
REQ-028 SHALL be able to accept start on the first rising edge after clear deasserts.

Configuration
REQ-029 SHALL, with macro SER_PARITY_EN defined, append one even-parity bit (XOR of the captured word) after the data bits: WIDTH+1 dS strobes, with done in cycle (WIDTH+1)*DIV+1.
REQ-030 SHALL, without SER_PARITY_EN, send exactly WIDTH bits and contain no parity logic.

Verification
REQ-031 SHALL pass: defaults, data_in=8'hA5, start pulse at edge 0 -> dS high in cycles 4,8,...,32, dI at those strobes 1,0,1,0,0,1,0,1, busy cycles 1-32, done only in cycle 33.
REQ-032 SHALL pass: start held high continuously, data_in=8'h3C -> frames back-to-back with a one-cycle IDLE between them, each frame bit-exact, start ignored while busy.
REQ-033 SHALL pass: abort=1 in cycle 14 of an 8'hFF frame -> IDLE at cycle 15, exactly 3 dS strobes seen, done never high.
REQ-034 SHALL pass: clear=0 asserted asynchronously in cycle 20 mid-frame -> busy, dS and dI low at once, done never high; a new start after release gives a correct full frame.
REQ-035 SHALL pass: DIV=1, WIDTH=4, data_in=4'b1001 -> dS high in cycles 1-4, dI at those cycles 1,0,0,1, done in cycle 5.
REQ-036 SHALL pass: SER_PARITY_EN defined, data_in=8'h07 -> 9 strobes, ninth bit 1, done in cycle 37.
